// File: rtl/deser_pkg.sv
// Shared constants and state encoding for the deserializer receive path.
package deser_pkg;

  localparam int DATA_W    = 16;
  localparam int LEN_W     = 8;
  localparam int BIT_CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RECV  = 2'd2
  } deser_state_e;

endpackage

// File: rtl/deserializer_if.sv
// Control, serial input and word output bundle of the deserializer.
interface deserializer_if;
  import deser_pkg::*;

  logic              start;
  logic [LEN_W-1:0]  length_in;
  logic              bit_i;
  logic              bit_valid_i;
  logic [DATA_W-1:0] data_o;
  logic              data_valid_o;
  logic [LEN_W-1:0]  word_cnt_o;
  logic              frame_done_o;
  logic              frame_err_o;
  logic              busy_o;

  modport master (
    output start, length_in, bit_i, bit_valid_i,
    input  data_o, data_valid_o, word_cnt_o, frame_done_o, frame_err_o, busy_o
  );

  modport slave (
    input  start, length_in, bit_i, bit_valid_i,
    output data_o, data_valid_o, word_cnt_o, frame_done_o, frame_err_o, busy_o
  );

endinterface

// File: rtl/deser_bit_assembler.sv
// Shift register and bit counter that rebuild one word from the serial stream.
// Bit order selected by DESERIALIZER_MSB_FIRST_EN (default: LSB first).
module deser_bit_assembler
  import deser_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_i,
  output logic [DATA_W-1:0] word_nxt_o,
  output logic              last_bit_o
);

  logic [DATA_W-1:0]    shreg;
  logic [BIT_CNT_W-1:0] bit_cnt;

  always_comb begin
`ifdef DESERIALIZER_MSB_FIRST_EN
    word_nxt_o = {shreg[DATA_W-2:0], bit_i};
`else
    word_nxt_o = {bit_i, shreg[DATA_W-1:1]};
`endif
  end

  // High while the bit being presented would complete the word.
  assign last_bit_o = (bit_cnt == BIT_CNT_W'(DATA_W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= word_nxt_o;
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/deserializer.sv
// Frame-level deserializer: arms on start, reassembles words, counts them against
// the programmed length. Bit order selectable via DESERIALIZER_MSB_FIRST_EN.
//
// state | meaning
// IDLE  | waiting for start; serial input ignored
// ARMED | length latched, waiting for the first valid bit
// RECV  | receiving; any invalid cycle aborts the frame
module deserializer
  import deser_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  deserializer_if.slave  bus
);

  deser_state_e state_q, state_d;

  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  word_cnt;
  logic [DATA_W-1:0] data_q;
  logic              data_valid_q, frame_done_q, frame_err_q;

  logic              load, shift, complete, last_word, err;
  logic [DATA_W-1:0] word_nxt;
  logic              last_bit;
  logic [LEN_W:0]    len_ext, cnt_inc;

  // A programmed length of 0 stands for a full 2^LEN_W-word frame.
  assign len_ext = (len_reg == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_reg};
  assign cnt_inc = {1'b0, word_cnt} + (LEN_W+1)'(1);

  deser_bit_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (load | err),
    .shift_en   (shift),
    .bit_i      (bus.bit_i),
    .word_nxt_o (word_nxt),
    .last_bit_o (last_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    shift     = 1'b0;
    complete  = 1'b0;
    last_word = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.bit_valid_i) begin
          shift   = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (bus.bit_valid_i) begin
          shift = 1'b1;
        end else begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (shift && last_bit) begin
      complete = 1'b1;
      if (cnt_inc == len_ext) begin
        last_word = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg      <= '0;
      word_cnt     <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_valid_q <= complete;
      frame_done_q <= last_word;
      frame_err_q  <= err;
      if (load) begin
        len_reg  <= bus.length_in;
        word_cnt <= '0;
      end else if (complete) begin
        data_q   <= word_nxt;
        word_cnt <= word_cnt + LEN_W'(1);
      end
    end
  end

  assign bus.data_o       = data_q;
  assign bus.data_valid_o = data_valid_q;
  assign bus.word_cnt_o   = word_cnt;
  assign bus.frame_done_o = frame_done_q;
  assign bus.frame_err_o  = frame_err_q;
  assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer with a queue-based scoreboard on output pulses.
module tb_deserializer;
  import deser_pkg::*;

  typedef struct {
    logic        dv;
    logic        done;
    logic        err;
    logic        busy;
    logic [15:0] data;
    logic [7:0]  cnt;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;
  int   last_dv_cycle = 0;
  exp_t exp_q[$];

  deserializer_if bus ();

  deserializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && (bus.data_valid_o || bus.frame_done_o || bus.frame_err_o)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, bus.data_valid_o, bus.frame_done_o, bus.frame_err_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_valid", bus.data_valid_o, e.dv);
        chk("frame_done", bus.frame_done_o, e.done);
        chk("frame_err",  bus.frame_err_o,  e.err);
        chk("data_o",     bus.data_o,       e.data);
        chk("word_cnt",   bus.word_cnt_o,   e.cnt);
        chk("busy",       bus.busy_o,       e.busy);
        if (e.gap != 0) chk("dv_spacing", cycle - last_dv_cycle, e.gap);
      end
      if (bus.data_valid_o) last_dv_cycle = cycle;
    end
  end

  task automatic push_word(input logic [15:0] d, input logic [7:0] c, input logic done, input int gap);
    exp_t e;
    e.dv = 1'b1; e.done = done; e.err = 1'b0; e.busy = !done;
    e.data = d; e.cnt = c; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [15:0] d, input logic [7:0] c);
    exp_t e;
    e.dv = 1'b0; e.done = 1'b0; e.err = 1'b1; e.busy = 1'b0;
    e.data = d; e.cnt = c; e.gap = 0;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] len);
    bus.start = 1'b1;
    bus.length_in = len;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy_o, 1'b1);
  endtask

  // Streams n bits of w; optionally pulses start (length 5) on bit start_at.
  task automatic send_bits(input logic [15:0] w, input int n, input int start_at);
    for (int b = 0; b < n; b++) begin
      bus.bit_valid_i = 1'b1;
`ifdef DESERIALIZER_MSB_FIRST_EN
      bus.bit_i = w[15-b];
`else
      bus.bit_i = w[b];
`endif
      if (b == start_at) begin
        bus.start = 1'b1;
        bus.length_in = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      tick();
      waited++;
    end
    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    bus.start = 1'b0;
    bus.length_in = '0;
    bus.bit_i = 1'b0;
    bus.bit_valid_i = 1'b0;
    repeat (3) tick();

    chk("rst_data_o",     bus.data_o,       16'h0);
    chk("rst_data_valid", bus.data_valid_o, 1'b0);
    chk("rst_word_cnt",   bus.word_cnt_o,   8'h0);
    chk("rst_frame_done", bus.frame_done_o, 1'b0);
    chk("rst_frame_err",  bus.frame_err_o,  1'b0);
    chk("rst_busy",       bus.busy_o,       1'b0);
    rst_n = 1'b1;
    // Valid bits in IDLE must be ignored.
    send_bits(16'hFFFF, 5, -1);
    bus.bit_valid_i = 1'b0;
    tick();

    // Single-word frame
    do_start(8'd1);
    push_word(16'hA5C3, 8'd1, 1'b1, 0);
    send_bits(16'hA5C3, 16, -1);
    bus.bit_valid_i = 1'b0;
    drain();
    chk("busy_after_frame1", bus.busy_o, 1'b0);

    // Three words streamed continuously
    do_start(8'd3);
    push_word(16'h0001, 8'd1, 1'b0, 0);
    push_word(16'h8000, 8'd2, 1'b0, 16);
    push_word(16'hFFFF, 8'd3, 1'b1, 16);
    send_bits(16'h0001, 16, -1);
    send_bits(16'h8000, 16, -1);
    send_bits(16'hFFFF, 16, -1);
    bus.bit_valid_i = 1'b0;
    drain();

    // Stream break after 20 bits of a 2-word frame
    do_start(8'd2);
    push_word(16'h1234, 8'd1, 1'b0, 0);
    push_err(16'h1234, 8'd1);
    send_bits(16'h1234, 16, -1);
    send_bits(16'h00FF, 4, -1);
    bus.bit_valid_i = 1'b0;
    drain();
    chk("busy_after_err", bus.busy_o, 1'b0);
    chk("cnt_after_err",  bus.word_cnt_o, 8'd1);

    // Length 0 means 256 words; counter wraps to 0 on the last
    do_start(8'd0);
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], ~i[7:0]};
      push_word(w, 8'(i + 1), (i == 255), (i == 0) ? 0 : 16);
      send_bits(w, 16, -1);
    end
    bus.bit_valid_i = 1'b0;
    drain();
    chk("cnt_after_256", bus.word_cnt_o, 8'd0);

    // start inside RECV is ignored; frame ends at the latched length of 2
    do_start(8'd2);
    push_word(16'h0F0F, 8'd1, 1'b0, 0);
    push_word(16'h3C3C, 8'd2, 1'b1, 16);
    send_bits(16'h0F0F, 16, -1);
    send_bits(16'h3C3C, 16, 5);
    bus.bit_valid_i = 1'b0;
    drain();
    chk("cnt_after_ignored_start", bus.word_cnt_o, 8'd2);

    // Reset after 7 bits clears everything at once with no pulse
    do_start(8'd4);
    send_bits(16'hBEEF, 7, -1);
    rst_n = 1'b0;
    #1;
    chk("midrst_data_o",     bus.data_o,       16'h0);
    chk("midrst_data_valid", bus.data_valid_o, 1'b0);
    chk("midrst_word_cnt",   bus.word_cnt_o,   8'h0);
    chk("midrst_frame_done", bus.frame_done_o, 1'b0);
    chk("midrst_frame_err",  bus.frame_err_o,  1'b0);
    chk("midrst_busy",       bus.busy_o,       1'b0);
    bus.bit_valid_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    drain();
    chk("busy_after_reset", bus.busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deserializer.md
# deserializer

Receive-side counterpart of the serializer stage. Samples a single-bit stream qualified by a valid strobe, reassembles it into 16-bit words, and counts words against a programmed frame length. Sits directly downstream of the serializer: it consumes that block's bit and bit-valid outputs in the serializer's read-clock domain. It delivers parallel words, a frame-done strobe and an error strobe to the capture logic that follows.

## Interface
- DATA_W, 16, word width; bits per reassembled word.
- LEN_W, 8, width of the frame length and word counter.
- clk  in  1  the single clock; the serializer's clk_o drives it.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  arms reception of one frame. Honoured only in IDLE.
- length_in  in  LEN_W  words per frame, latched on an accepted start. A value of 0 means 2^LEN_W (256).
- bit_i  in  1  serial data bit.
- bit_valid_i  in  1  bit_i is valid this cycle.
- data_o  out  DATA_W  last reassembled word. Holds its value between updates.
- data_valid_o  out  1  one-cycle pulse: data_o is new.
- word_cnt_o  out  LEN_W  words delivered in the current or last frame.
- frame_done_o  out  1  one-cycle pulse on the final word of a frame.
- frame_err_o  out  1  one-cycle pulse: the stream broke mid-frame.
- busy_o  out  1  high in ARMED and RECV.

## Operation
- States: IDLE, ARMED, RECV.
- IDLE:
  - On start, latch length_in into len_reg, clear word_cnt_o, bit_cnt and the shift register, then go to ARMED.
  - bit_valid_i is ignored in IDLE.
- ARMED:
  - Wait for bit_valid_i. The first valid cycle is sampled as bit 0 of word 0, and the state moves to RECV.
  - start is ignored while in ARMED.
- RECV, on each bit_valid_i=1 cycle:
  - Shift in the bit: shreg <= {bit_i, shreg[DATA_W-1:1]} (LSB first).
  - Increment the 4-bit bit_cnt, which wraps 15 to 0.
- Word completion (bit_cnt==15 while valid):
  - Load data_o with the completed word and pulse data_valid_o.
  - Increment word_cnt_o.
  - If word_cnt_o+1 equals len_reg (compare in LEN_W+1 bits, with len_reg 0 mapped to 256), pulse frame_done_o and go to IDLE.
- Stream break: bit_valid_i=0 in RECV pulses frame_err_o, drops the partial word, returns to IDLE, and leaves word_cnt_o holding the words already delivered. Completed words are never retracted.
- start during ARMED or RECV is ignored. It has no effect on len_reg or on the counters.
- Reset mid-frame: all state returns to its reset value immediately. No pulse is generated.

## Timing
- Reset values:
  - data_o=0, data_valid_o=0, word_cnt_o=0, frame_done_o=0, frame_err_o=0, busy_o=0.
  - Internally, state is IDLE, bit_cnt=0 and shreg=0.
- start at edge N moves the state to ARMED at N+1. busy_o is high from N+1. A bit_valid_i high in the same cycle as start is not sampled.
- Latency: data_valid_o and the new data_o appear at the edge that samples the 16th bit. They are registered outputs, visible the cycle after that bit is presented.
- frame_done_o is coincident with the final data_valid_o. busy_o falls at the same edge.
- frame_err_o is registered, one cycle after the low bit_valid_i. busy_o falls at the same edge.
- Back-to-back frames: the earliest new start is the cycle frame_done_o is high, which is when the state is IDLE. Bits arriving before re-arm are discarded.
- The block needs continuous bit_valid_i within a frame. This matches the serializer, which holds valid for length×16 consecutive cycles.

## Configuration
- DESERIALIZER_MSB_FIRST_EN:
  - Defined: shreg <= {shreg[DATA_W-2:0], bit_i}, so the first received bit becomes data_o[15].
  - Undefined (default): LSB first as described above, so the first bit becomes data_o[0], matching the serializer's output order.
- Counters, the state machine and timing are identical in both builds.

## Structure
- Package deser_pkg holds:
  - DATA_W and LEN_W defaults.
  - The state enum (IDLE, ARMED, RECV).
  - The BIT_CNT_W = $clog2(DATA_W) constant.
- One sub-module, deser_bit_assembler, holds the shift register, bit_cnt and the word-complete flag, and contains the DESERIALIZER_MSB_FIRST_EN ifdef. The top level holds the FSM, len_reg, word_cnt_o and the output registers.

## Test plan
- Reset, then start with length_in=1, then 16 valid bits of 0xA5C3 LSB first → data_valid_o and frame_done_o pulse together with data_o=0xA5C3, word_cnt_o=1, busy_o=0.
- length_in=3 with words 0x0001, 0x8000, 0xFFFF streamed continuously → three data_valid_o pulses exactly 16 cycles apart. frame_done_o fires only on the third, with word_cnt_o=3.
- length_in=2, then bit_valid_i dropped after 20 bits → one word delivered, then frame_err_o pulses, word_cnt_o=1, no frame_done_o, state returns to IDLE.
- length_in=0 with 4096 continuous valid bits → 256 data_valid_o pulses. frame_done_o fires on the 256th only, and word_cnt_o has wrapped to 0.
- Mid-frame checks:
  - start pulsed in RECV with length_in=5 → ignored; the frame completes at the originally latched length.
  - rst_n asserted after 7 bits → every output reads 0 immediately, with no pulse.
- Build with DESERIALIZER_MSB_FIRST_EN, then stream 0xA5C3 MSB first → data_o=0xA5C3.
